// File: rtl/clock_set_if.sv
// Edit-controller bus between the button/timekeeping side and the set sequencer.
interface clock_set_if;
  logic [1:0] clk_mode;
  logic [1:0] vButton;
  logic [7:0] cur_a;
  logic [7:0] cur_b;
  logic [7:0] cur_c;
  logic [7:0] set_a;
  logic [7:0] set_b;
  logic [7:0] set_c;
  logic [1:0] field_sel;
  logic       blink;
  logic       editing;
  logic       load_time;
  logic       load_date;
  logic       load_alarm;

  modport master (
    output clk_mode, vButton, cur_a, cur_b, cur_c,
    input  set_a, set_b, set_c, field_sel, blink, editing,
           load_time, load_date, load_alarm
  );
  modport slave (
    input  clk_mode, vButton, cur_a, cur_b, cur_c,
    output set_a, set_b, set_c, field_sel, blink, editing,
           load_time, load_date, load_alarm
  );
endinterface

// File: rtl/clock_set_controller.sv
// Time/date/alarm edit sequencer: snapshot on mode entry, per-field BCD stepping,
// one-cycle commit strobe, and cursor select/blink for the LCD formatter.
module clock_set_controller #(
  parameter int M_FREQ   = 1,
  parameter bit BLINK_EN = 1'b1
) (
  input logic        mclk,
  input logic        rst,
  clock_set_if.slave bus
);
  localparam int HALF = (M_FREQ / 2 > 1) ? M_FREQ / 2 : 1;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [2:0] {IDLE, EDIT_A, EDIT_B, EDIT_C, COMMIT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    set_a_q, set_b_q, set_c_q;
  logic [7:0]    set_a_d, set_b_d, set_c_d;
  logic [7:0]    inc_a, inc_b, inc_c, dim_cur;
  logic          mode_chg, snap, edit_q, edit_d, force_b;
  logic          blink_q;
  logic [CW-1:0] bcnt;

  // Anything not a valid BCD value inside [lo, hi) restarts at lo.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v < lo || v >= hi) return lo;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  function automatic logic [7:0] dim(input logic [7:0] mo, input logic [7:0] yy);
    logic [7:0] y;
    y = 8'(yy[7:4]) * 8'd10 + 8'(yy[3:0]);
    case (mo)
      8'h02:                      return (y[1:0] == 2'b00) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  always_comb begin
    dim_cur = dim(set_b_q, set_c_q);
    inc_a   = '0;
    inc_b   = '0;
    inc_c   = '0;
    case (mode_q)
      2'd2: begin
        inc_a = bcd_inc(set_a_q, 8'h01, dim_cur);
        inc_b = bcd_inc(set_b_q, 8'h01, 8'h12);
        inc_c = bcd_inc(set_c_q, 8'h00, 8'h99);
      end
      2'd3: begin
        inc_a = bcd_inc(set_a_q, 8'h00, 8'h23);
        inc_b = bcd_inc(set_b_q, 8'h00, 8'h59);
        inc_c = bcd_inc(set_c_q, 8'h00, 8'h01);
      end
      default: begin
        inc_a = bcd_inc(set_a_q, 8'h00, 8'h23);
        inc_b = bcd_inc(set_b_q, 8'h00, 8'h59);
        inc_c = bcd_inc(set_c_q, 8'h00, 8'h59);
      end
    endcase
  end

  assign mode_chg = (bus.clk_mode != mode_q);
  assign snap     = mode_chg && (bus.clk_mode != 2'd0);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    set_a_d = set_a_q;
    set_b_d = set_b_q;
    set_c_d = set_c_q;
    if (mode_chg) begin
      mode_d = bus.clk_mode;
      if (snap) begin
        state_d = EDIT_A;
        set_a_d = bus.cur_a;
        set_b_d = bus.cur_b;
        set_c_d = bus.cur_c;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        EDIT_A: if (bus.vButton[1]) state_d = EDIT_B;
                else if (bus.vButton[0]) set_a_d = inc_a;
        EDIT_B: if (bus.vButton[1]) state_d = EDIT_C;
                else if (bus.vButton[0]) set_b_d = inc_b;
        EDIT_C: if (bus.vButton[1]) begin
                  state_d = COMMIT;
                  // Day may exceed the month just chosen; clamp before the strobe.
                  if (mode_q == 2'd2 && set_a_q > dim_cur) set_a_d = dim_cur;
                end else if (bus.vButton[0]) begin
                  set_c_d = inc_c;
                end
        COMMIT: state_d = HOLD;
        default: ;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      set_a_q <= 8'h00;
      set_b_q <= 8'h00;
      set_c_q <= 8'h00;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      set_a_q <= set_a_d;
      set_b_q <= set_b_d;
      set_c_q <= set_c_d;
    end
  end

  assign edit_q  = (state_q == EDIT_A) || (state_q == EDIT_B) || (state_q == EDIT_C);
  assign edit_d  = (state_d == EDIT_A) || (state_d == EDIT_B) || (state_d == EDIT_C);
  assign force_b = snap || (edit_q && (bus.vButton != 2'b00));

  // Cursor restarts visible on entry or any press so the user sees the field react.
  always_ff @(posedge mclk) begin
    if (rst || force_b || !edit_d) begin
      blink_q <= 1'b1;
      bcnt    <= '0;
    end else if (bcnt == CW'(HALF - 1)) begin
      blink_q <= BLINK_EN ? ~blink_q : 1'b1;
      bcnt    <= '0;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  assign bus.set_a      = set_a_q;
  assign bus.set_b      = set_b_q;
  assign bus.set_c      = set_c_q;
  assign bus.editing    = edit_q;
  assign bus.blink      = blink_q;
  assign bus.field_sel  = (state_q == EDIT_A) ? 2'd0 :
                          (state_q == EDIT_B) ? 2'd1 :
                          (state_q == EDIT_C) ? 2'd2 : 2'd3;
  assign bus.load_time  = (state_q == COMMIT) && (mode_q == 2'd1);
  assign bus.load_date  = (state_q == COMMIT) && (mode_q == 2'd2);
  assign bus.load_alarm = (state_q == COMMIT) && (mode_q == 2'd3);
endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with a decimal-arithmetic reference model.
module tb_clock_set_controller;
  localparam int HALF = 2;  // M_FREQ = 4
  localparam int P_IDLE = 0, P_EDIT = 1, P_COMMIT = 2, P_HOLD = 3;
  localparam int DIM_T [0:11] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  logic mclk = 1'b0;
  logic rst;
  bit   chk_en = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  clock_set_if bus();

  clock_set_controller #(.M_FREQ(4), .BLINK_EN(1'b1)) dut (
    .mclk(mclk), .rst(rst), .bus(bus)
  );

  always #5 mclk = ~mclk;

  // Reference model state (decimal values, cycles since last blink restart)
  int m_mode, m_phase, m_field, m_k, lo, hi;
  int m_v [3];

  function automatic int b2i(input logic [7:0] x);
    return int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int mdim(input int mo, input int yy);
    if (mo < 1 || mo > 12) return 31;
    if (mo == 2 && yy % 4 == 0) return 29;
    return DIM_T[mo - 1];
  endfunction

  always @(posedge mclk) begin
    if (rst) begin
      m_mode = 0; m_phase = P_IDLE; m_field = 0; m_k = 0;
      m_v[0] = 0; m_v[1] = 0; m_v[2] = 0;
    end else if (bus.clk_mode != 2'(m_mode)) begin
      m_mode = int'(bus.clk_mode);
      m_k = 0;
      if (m_mode != 0) begin
        m_phase = P_EDIT; m_field = 0;
        m_v[0] = b2i(bus.cur_a); m_v[1] = b2i(bus.cur_b); m_v[2] = b2i(bus.cur_c);
      end else begin
        m_phase = P_IDLE;
      end
    end else if (m_phase == P_EDIT) begin
      if (bus.vButton[1]) begin
        m_k = 0;
        if (m_field < 2) m_field++;
        else begin
          if (m_mode == 2 && m_v[0] > mdim(m_v[1], m_v[2])) m_v[0] = mdim(m_v[1], m_v[2]);
          m_phase = P_COMMIT;
        end
      end else if (bus.vButton[0]) begin
        m_k = 0;
        lo = (m_mode == 2 && m_field < 2) ? 1 : 0;
        case (m_mode)
          1:       hi = (m_field == 0) ? 23 : 59;
          2:       hi = (m_field == 0) ? mdim(m_v[1], m_v[2]) : (m_field == 1) ? 12 : 99;
          default: hi = (m_field == 0) ? 23 : (m_field == 1) ? 59 : 1;
        endcase
        m_v[m_field] = (m_v[m_field] < lo || m_v[m_field] >= hi) ? lo : m_v[m_field] + 1;
      end else begin
        m_k++;
      end
    end else if (m_phase == P_COMMIT) begin
      m_phase = P_HOLD;
    end
  end

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge mclk) begin
    if (chk_en) begin
      cmp("set_a", bus.set_a, i2b(m_v[0]));
      cmp("set_b", bus.set_b, i2b(m_v[1]));
      cmp("set_c", bus.set_c, i2b(m_v[2]));
      cmp("field_sel", 8'(bus.field_sel), 8'((m_phase == P_EDIT) ? m_field : 3));
      cmp("editing", 8'(bus.editing), 8'(m_phase == P_EDIT));
      cmp("blink", 8'(bus.blink), 8'((m_phase != P_EDIT) || ((m_k / HALF) % 2 == 0)));
      cmp("load_time", 8'(bus.load_time), 8'(m_phase == P_COMMIT && m_mode == 1));
      cmp("load_date", 8'(bus.load_date), 8'(m_phase == P_COMMIT && m_mode == 2));
      cmp("load_alarm", 8'(bus.load_alarm), 8'(m_phase == P_COMMIT && m_mode == 3));
    end
  end

  // All tasks start and end on a falling edge.
  task automatic pulse(input logic [1:0] vb);
    bus.vButton = vb;
    @(negedge mclk);
    bus.vButton = 2'b00;
  endtask

  task automatic set_mode(input logic [1:0] m);
    bus.clk_mode = m;
    @(negedge mclk);
  endtask

  task automatic set_cur(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    bus.cur_a = a; bus.cur_b = b; bus.cur_c = c;
  endtask

  initial begin
    rst = 1'b1;
    bus.clk_mode = 2'd0;
    bus.vButton = 2'b00;
    set_cur(8'h23, 8'h59, 8'h58);
    @(posedge mclk);
    @(negedge mclk);
    chk_en = 1'b1;
    rst = 1'b0;
    cmp("rst_field_sel", 8'(bus.field_sel), 8'd3);
    cmp("rst_set_a", bus.set_a, 8'h00);
    cmp("rst_blink", 8'(bus.blink), 8'd1);
    cmp("rst_editing", 8'(bus.editing), 8'd0);

    // Time set with wraps on every field, then commit
    set_mode(2'd1);
    cmp("t_snap_a", bus.set_a, 8'h23);
    cmp("t_sel0", 8'(bus.field_sel), 8'd0);
    pulse(2'b01); cmp("t_hh_wrap", bus.set_a, 8'h00);
    pulse(2'b10); pulse(2'b01); cmp("t_mm_wrap", bus.set_b, 8'h00);
    pulse(2'b10); pulse(2'b01); pulse(2'b01); cmp("t_ss_wrap", bus.set_c, 8'h00);
    pulse(2'b10); cmp("t_load", 8'(bus.load_time), 8'd1);
    @(negedge mclk);
    cmp("t_load_off", 8'(bus.load_time), 8'd0);
    cmp("t_hold_sel", 8'(bus.field_sel), 8'd3);

    // Date clamp, non-leap then leap
    set_cur(8'h31, 8'h01, 8'h23);
    set_mode(2'd2);
    pulse(2'b10); pulse(2'b01); cmp("d_mo", bus.set_b, 8'h02);
    pulse(2'b10); pulse(2'b10);
    cmp("d_load", 8'(bus.load_date), 8'd1);
    cmp("d_clamp28", bus.set_a, 8'h28);
    set_cur(8'h31, 8'h01, 8'h24);
    set_mode(2'd0); set_mode(2'd2);
    pulse(2'b10); pulse(2'b01); pulse(2'b10); pulse(2'b10);
    cmp("d_clamp29", bus.set_a, 8'h29);

    // Day wrap against month length
    set_cur(8'h29, 8'h02, 8'h24);
    set_mode(2'd0); set_mode(2'd2);
    pulse(2'b01); cmp("d_wrap_feb", bus.set_a, 8'h01);
    set_cur(8'h30, 8'h04, 8'h01);
    set_mode(2'd0); set_mode(2'd2);
    pulse(2'b01); cmp("d_wrap_apr", bus.set_a, 8'h01);

    // Abandon mid-edit into alarm mode
    set_cur(8'h12, 8'h34, 8'h56);
    set_mode(2'd0); set_mode(2'd1);
    pulse(2'b01); pulse(2'b10);
    set_cur(8'h07, 8'h30, 8'h00);
    set_mode(2'd3);
    cmp("ab_snap_a", bus.set_a, 8'h07);
    cmp("ab_sel0", 8'(bus.field_sel), 8'd0);
    pulse(2'b10); pulse(2'b10);
    pulse(2'b01); cmp("al_c_on", bus.set_c, 8'h01);
    pulse(2'b01); cmp("al_c_off", bus.set_c, 8'h00);

    // Out-of-range snapshot restarts at the minimum
    set_cur(8'h25, 8'h00, 8'h00);
    set_mode(2'd0); set_mode(2'd1);
    pulse(2'b01); cmp("oor_hh", bus.set_a, 8'h00);

    // Both buttons: advance wins; reset mid-edit kills the strobe
    set_cur(8'h12, 8'h34, 8'h56);
    set_mode(2'd0); set_mode(2'd1);
    pulse(2'b11);
    cmp("both_sel", 8'(bus.field_sel), 8'd1);
    cmp("both_a", bus.set_a, 8'h12);
    pulse(2'b10);
    rst = 1'b1; bus.vButton = 2'b10;
    @(negedge mclk);
    rst = 1'b0; bus.vButton = 2'b00;
    cmp("rr_load", 8'(bus.load_time), 8'd0);
    cmp("rr_sel", 8'(bus.field_sel), 8'd3);
    cmp("rr_set_a", bus.set_a, 8'h00);
    @(negedge mclk);
    cmp("rr_resnap", bus.set_a, 8'h12);

    // Blink pattern with half-period 2, restarted by a press
    cmp("bl0", 8'(bus.blink), 8'd1);
    @(negedge mclk); cmp("bl1", 8'(bus.blink), 8'd1);
    @(negedge mclk); cmp("bl2", 8'(bus.blink), 8'd0);
    @(negedge mclk); cmp("bl3", 8'(bus.blink), 8'd0);
    @(negedge mclk); cmp("bl4", 8'(bus.blink), 8'd1);
    pulse(2'b01);    cmp("bl_press", 8'(bus.blink), 8'd1);
    @(negedge mclk); cmp("bl_p1", 8'(bus.blink), 8'd1);
    @(negedge mclk); cmp("bl_p2", 8'(bus.blink), 8'd0);
    set_mode(2'd0);
    repeat (4) begin
      @(negedge mclk); cmp("bl_idle", 8'(bus.blink), 8'd1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Sequences user editing of the digital clock's time, date and alarm registers from the two debounced virtual buttons.
- Snapshots the live values when a set mode is entered and steps through three BCD fields per mode with per-field wrap.
- Commits the edited values with a one-cycle load strobe to the timekeeping core.
- Drives field-select and blink outputs so the LCD formatter can show the cursor.

Parameters:
M_FREQ, 1, main clock frequency in Hz; blink half-period = max(M_FREQ/2, 1) cycles
BLINK_EN, 1, 1 = blink toggles; 0 = blink held at 1

Ports:
mclk  in  1  main clock
rst  in  1  synchronous, active-high reset
clk_mode  in  2  0 run, 1 set time, 2 set date, 3 set alarm
vButton  in  2  one-cycle pulses; [0] increment field, [1] next field/commit
cur_a  in  8  live BCD field A (mode1 HH, mode2 DD, mode3 alarm HH)
cur_b  in  8  live BCD field B (MM / MO / alarm MM)
cur_c  in  8  live BCD field C (SS / YY / alarm enable 00 or 01)
set_a  out  8  edited BCD field A
set_b  out  8  edited BCD field B
set_c  out  8  edited BCD field C
field_sel  out  2  0/1/2 = field A/B/C under edit; 3 = none
blink  out  1  cursor visibility for the selected field
editing  out  1  high in EDIT states
load_time  out  1  one-cycle commit strobe, mode 1
load_date  out  1  one-cycle commit strobe, mode 2
load_alarm  out  1  one-cycle commit strobe, mode 3

Behaviour:
- Reset: state IDLE, mode_q=0, set_a/b/c=8'h00, field_sel=3, blink=1, editing=0, all load_*=0, blink counter=0.
- States: IDLE, EDIT_A, EDIT_B, EDIT_C, COMMIT, HOLD.
- Mode change: on any edge where clk_mode != mode_q, mode_q <= clk_mode and the current edit is abandoned with no strobe.
  - New mode nonzero: set_a/b/c <= cur_a/b/c, state EDIT_A. editing=1 and field_sel=0 are visible the cycle after the edge. Applies from any state.
  - New mode 0: state IDLE.
- Edit-state buttons:
  - vButton[0]: selected field increments in BCD with wrap.
  - vButton[1]: advances A->B->C; from EDIT_C goes to COMMIT.
  - Both buttons high: vButton[1] wins and the increment is dropped.
  - Buttons are ignored in IDLE, COMMIT and HOLD.
  - A mode change in the same cycle as a button takes priority over the button.
- Wrap rules:
  - Mode 1: HH 00..23, MM 00..59, SS 00..59; max wraps to 00.
  - Mode 2: DD 01..dim, MO 01..12, YY 00..99; DD and MO wrap to 01.
  - dim = 31/28/31/30/31/30/31/31/30/31/30/31; February = 29 when YY mod 4 == 0 (years 2000-2099).
  - DD wraps against dim of the current set_b/set_c.
  - Mode 3: HH 00..23, MM 00..59, C toggles 00<->01.
- Out-of-range snapshots: if a snapshotted field is out of range, the first increment yields the wrap minimum.
- COMMIT (exactly one cycle):
  - Mode 2: if DD > dim(MO,YY), set_a is clamped to dim on entry to COMMIT, i.e. in the same edge as leaving EDIT_C.
  - The load_* strobe matching mode_q is high for this one cycle, with set_a/b/c stable and final.
  - Next state is HOLD.
- HOLD: editing=0, field_sel=3, set_* retain values; stays until clk_mode changes.
- IDLE: editing=0, field_sel=3; set_* retain last values.
- blink:
  - Forced 1 on entry to any EDIT state and on any vButton pulse; the counter restarts at the same time.
  - Otherwise toggles every blink half-period while in an EDIT state.
  - Held at 1 outside EDIT states.
  - With M_FREQ=1 the half-period is 1 cycle.
- Reset mid-edit: returns to the reset state, no strobe. mode_q=0, so a nonzero clk_mode held through reset re-snapshots on the first post-reset edge.

Test Plan:
- Time set, increment and commit: rst, cur={23,59,58}, clk_mode 0->1 -> next cycle set={23,59,58}, field_sel=0. Then 1x vB0 -> set_a=00; vB1, 1x vB0 -> set_b=00; vB1, 2x vB0 -> set_c=00. vB1 -> load_time=1 for exactly one cycle with set={00,00,00}, then HOLD, field_sel=3.
- Date clamp: mode 2, cur={31,01,23}; vB1, 1x vB0 -> MO=02; vB1, vB1 -> load_date pulse with set={28,02,23}. Repeat with YY=24 -> set_a=29.
- DD wrap: mode 2, cur={29,02,24}; 1x vB0 -> set_a=01. Cur={30,04,01}; 1x vB0 -> 01.
- Abandon: mode 1, edit twice, switch clk_mode 1->3 mid EDIT_B -> no load_* pulse; set_* re-snapshot from alarm cur_*; field_sel=0. Alarm C toggles 00->01->00.
- Simultaneous buttons: vB0 and vB1 both high in EDIT_A -> field_sel=1, set_a unchanged. rst high in EDIT_C with vB1 -> no strobe; all outputs at reset values next cycle.
- Blink (M_FREQ=4): in EDIT_A, blink pattern 1,1,0,0,1,1...; a vB0 pulse forces 1 and restarts the counter. IDLE -> blink constant 1.
